i2c_target_regfile: RTL

//  Clocked I2C target (responder) answering i2c_master_controller. Holds a small register file reachable over the bus.

---
 rtl/i2c_target_regfile.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target with a small register file.
// Bus pins are oversampled on clk; no clock stretching.
module i2c_target_regfile #(
  parameter logic [6:0] TARGET_ADDR = 7'h2A,
  parameter int         REG_COUNT   = 4,
  parameter logic [7:0] RESET_VAL   = 8'h00,
  localparam int PW =
    (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scl,
  input  logic                   sda_in,
  output logic                   sda_oe,
  output logic                   busy,
  output logic                   wr_strobe,
  output logic [PW-1:0]          wr_ptr,
  output logic [7:0]             wr_data,
  output logic [8*REG_COUNT-1:0] reg_q
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_AACK, S_PTR, S_PACK,
    S_WDATA, S_WACK, S_RDATA, S_RACK
  } state_t;

  state_t        r_state, w_state;
  logic          r_scl_s1, r_scl_s2, r_scl_d;
  logic          r_sda_s1, r_sda_s2, r_sda_d;
  logic [3:0]    r_cnt, w_cnt;
  logic [7:0]    r_shift, w_shift;
  logic [PW-1:0] r_ptr, w_ptr;
  logic          r_oe, w_oe;
  logic          r_busy, w_busy;
  logic          r_stb, w_stb;
  logic [PW-1:0] r_wptr, w_wptr;
  logic [7:0]    r_wdata, w_wdata;
  logic [7:0]    r_regs [REG_COUNT];
  logic [7:0]    w_rd;
  logic          w_rise, w_fall;
  logic          w_start, w_stop;

  // Two-flop synchronizers plus one delay stage for edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_rise  = r_scl_s2 & ~r_scl_d;
  assign w_fall  = ~r_scl_s2 & r_scl_d;
  assign w_start = r_scl_s2 & r_scl_d
                 & r_sda_d & ~r_sda_s2;
  assign w_stop  = r_scl_s2 & r_scl_d
                 & ~r_sda_d & r_sda_s2;
  assign w_rd    = r_regs[r_ptr];

  // Protocol state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_ptr   <= '0;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_stb   <= 1'b0;
      r_wptr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_shift <= w_shift;
      r_ptr   <= w_ptr;
      r_oe    <= w_oe;
      r_busy  <= w_busy;
      r_stb   <= w_stb;
      r_wptr  <= w_wptr;
      r_wdata <= w_wdata;
    end
  end

  // Next-state logic; bytes complete at the SCL fall after bit 0
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_shift = r_shift;
    w_ptr   = r_ptr;
    w_oe    = r_oe;
    w_busy  = r_busy;
    w_stb   = 1'b0;
    w_wptr  = r_wptr;
    w_wdata = r_wdata;
    if (w_start) begin
      w_state = S_ADDR;
      w_cnt   = '0;
      w_oe    = 1'b0;
      w_busy  = 1'b0;
    end else if (w_stop) begin
      w_state = S_IDLE;
      w_cnt   = '0;
      w_oe    = 1'b0;
      w_busy  = 1'b0;
    end else begin
      unique case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_rise && r_cnt != 4'd8) begin
            w_shift = {r_shift[6:0], r_sda_s2};
            w_cnt   = r_cnt + 4'd1;
          end else if (w_fall && r_cnt == 4'd8) begin
            w_cnt = '0;
            w_oe  = 1'b1;
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == TARGET_ADDR) begin
                w_state = S_AACK;
                w_busy  = 1'b1;
              end else begin
                w_state = S_IDLE;
                w_oe    = 1'b0;
              end
            end else if (r_state == S_PTR) begin
              w_ptr   = r_shift[PW-1:0];
              w_state = S_PACK;
            end else begin
              w_stb   = 1'b1;
              w_wptr  = r_ptr;
              w_wdata = r_shift;
              w_ptr   = r_ptr + 1'b1;
              w_state = S_WACK;
            end
          end
        end
        S_AACK: begin
          if (w_fall) begin
            w_cnt = '0;
            if (r_shift[0]) begin
              w_state = S_RDATA;
              w_shift = w_rd;
              w_oe    = ~w_rd[7];
            end else begin
              w_state = S_PTR;
              w_oe    = 1'b0;
            end
          end
        end
        S_PACK, S_WACK: begin
          if (w_fall) begin
            w_cnt   = '0;
            w_oe    = 1'b0;
            w_state = S_WDATA;
          end
        end
        S_RDATA: begin
          if (w_rise && r_cnt != 4'd8) begin
            w_cnt = r_cnt + 4'd1;
          end else if (w_fall && r_cnt == 4'd8) begin
            w_cnt   = '0;
            w_oe    = 1'b0;
            w_state = S_RACK;
          end else if (w_fall && r_cnt != 4'd0) begin
            w_shift = {r_shift[6:0], 1'b0};
            w_oe    = ~r_shift[6];
          end
        end
        S_RACK: begin
          if (w_rise && r_cnt == 4'd0) begin
            w_ptr = r_ptr + 1'b1;
            if (!r_sda_s2) w_cnt = 4'd1;
            else w_state = S_IDLE;
          end else if (w_fall && r_cnt == 4'd1) begin
            w_cnt   = '0;
            w_state = S_RDATA;
            w_shift = w_rd;
            w_oe    = ~w_rd[7];
          end
        end
        default: ;
      endcase
    end
  end

  // Register file, written only by completed bus bytes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++)
        r_regs[i] <= RESET_VAL;
    end else if (w_stb) begin
      r_regs[r_ptr] <= r_shift;
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_q
    assign reg_q[8*g +: 8] = r_regs[g];
  end

  assign sda_oe    = r_oe;
  assign busy      = r_busy;
  assign wr_strobe = r_stb;
  assign wr_ptr    = r_wptr;
  assign wr_data   = r_wdata;

endmodule
